// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use/RAW stalls, branch flush,
// data-memory freeze with timeout, and a saturating stall counter. Build option: FORWARDING_EN.
module pipeline_hazard_ctrl #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  id_src1,
  input  logic [3:0]  id_src2,
  input  logic        id_use_src2,
  input  logic [3:0]  exe_dest,
  input  logic        exe_wb_en,
  input  logic        exe_mem_r_en,
  input  logic [3:0]  mem_dest,
  input  logic        mem_wb_en,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic        branch_taken,
  output logic        hazard_stall,
  output logic        id_bubble,
  output logic        flush,
  output logic        mem_freeze,
  output logic        fwd_en,
  output logic        mem_timeout,
  output logic [15:0] stall_count
);

  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] MEM_WAIT = 1'b1;
  localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_MAX);

  logic [0:0]  state, state_next;
  logic [7:0]  wait_cnt, wait_cnt_next;
  logic        timeout_q, timeout_next;
  logic [15:0] stall_cnt_q;
  logic        freeze_raw;
  logic        data_hazard;
  logic        src_hit_exe;
  logic        src_hit_mem;

  // Register 0 is an ordinary register here; any match counts.
  assign src_hit_exe = (id_src1 == exe_dest) || (id_use_src2 && (id_src2 == exe_dest));
  assign src_hit_mem = (id_src1 == mem_dest) || (id_use_src2 && (id_src2 == mem_dest));

`ifdef FORWARDING_EN
  logic unused_mem_stage;
  assign unused_mem_stage = ^{mem_dest, mem_wb_en, src_hit_mem};
  assign fwd_en      = 1'b1;
  assign data_hazard = exe_mem_r_en & exe_wb_en & src_hit_exe;
`else
  logic unused_load_flag;
  assign unused_load_flag = exe_mem_r_en;
  assign fwd_en      = 1'b0;
  assign data_hazard = (exe_wb_en & src_hit_exe) | (mem_wb_en & src_hit_mem);
`endif

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    timeout_next  = timeout_q;
    freeze_raw    = 1'b0;
    case (state)
      RUN: begin
        if (mem_req && !mem_ready) begin
          freeze_raw    = 1'b1;
          state_next    = MEM_WAIT;
          wait_cnt_next = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_next    = RUN;
          wait_cnt_next = '0;
        end else if (wait_cnt == WAIT_LIMIT) begin
          // Give up: release the pipeline this cycle, flag the error next cycle.
          state_next    = RUN;
          wait_cnt_next = '0;
          timeout_next  = 1'b1;
        end else begin
          freeze_raw    = 1'b1;
          wait_cnt_next = wait_cnt + 8'd1;
        end
      end
      default: begin
        state_next    = RUN;
        wait_cnt_next = '0;
      end
    endcase
  end

  always_comb begin
    hazard_stall = 1'b0;
    id_bubble    = 1'b0;
    flush        = 1'b0;
    mem_freeze   = 1'b0;
    if (!rst) begin
      if (freeze_raw) begin
        mem_freeze = 1'b1;
      end else if (branch_taken) begin
        flush     = 1'b1;
        id_bubble = 1'b1;
      end else if (data_hazard) begin
        hazard_stall = 1'b1;
        id_bubble    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state     <= state_next;
      wait_cnt  <= wait_cnt_next;
      timeout_q <= timeout_next;
      if ((hazard_stall || mem_freeze) && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  assign mem_timeout = timeout_q & ~rst;
  assign stall_count = rst ? '0 : stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized and directed bench for pipeline_hazard_ctrl against a behavioural model
// that tracks memory accesses as "frozen cycles so far" rather than FSM states.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned WAIT_MAX = 4;
`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  id_src1, id_src2, exe_dest, mem_dest;
  logic        id_use_src2, exe_wb_en, exe_mem_r_en, mem_wb_en;
  logic        mem_req, mem_ready, branch_taken;
  logic        hazard_stall, id_bubble, flush, mem_freeze, fwd_en, mem_timeout;
  logic [15:0] stall_count;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src2(id_src2), .id_use_src2(id_use_src2),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .mem_req(mem_req), .mem_ready(mem_ready), .branch_taken(branch_taken),
    .hazard_stall(hazard_stall), .id_bubble(id_bubble), .flush(flush),
    .mem_freeze(mem_freeze), .fwd_en(fwd_en), .mem_timeout(mem_timeout),
    .stall_count(stall_count)
  );

  int checks = 0;
  int errors = 0;

  // Model state: is an access outstanding, how many cycles it has frozen so far.
  bit          m_in_access;
  int unsigned m_frozen;
  bit          m_timeout;
  int unsigned m_count;
  logic [5:0]  exp_vec;   // {hazard_stall, id_bubble, flush, mem_freeze, fwd_en, mem_timeout}
  logic [15:0] exp_cnt;
  bit          exp_fr, exp_hz;

  function automatic bit reads(input logic [3:0] r);
    return (id_src1 == r) || (id_use_src2 && (id_src2 == r));
  endfunction

  function automatic void model_eval();
    bit fr, br, hz, dh;
    if (rst) begin
      exp_vec = {4'b0000, FWD, 1'b0};
      exp_cnt = '0;
      exp_fr  = 1'b0;
      exp_hz  = 1'b0;
      return;
    end
    fr = !mem_ready && (m_in_access ? (m_frozen < WAIT_MAX) : mem_req);
    if (FWD) dh = exe_mem_r_en && exe_wb_en && reads(exe_dest);
    else     dh = (exe_wb_en && reads(exe_dest)) || (mem_wb_en && reads(mem_dest));
    br = !fr && branch_taken;
    hz = !fr && !br && dh;
    exp_vec = {hz, br | hz, br, fr, FWD, m_timeout};
    exp_cnt = 16'(m_count);
    exp_fr  = fr;
    exp_hz  = hz;
  endfunction

  function automatic void model_advance();
    if (rst) begin
      m_in_access = 1'b0;
      m_frozen    = 0;
      m_timeout   = 1'b0;
      m_count     = 0;
      return;
    end
    if ((exp_hz || exp_fr) && m_count < 65535) m_count++;
    if (exp_fr) begin
      m_in_access = 1'b1;
      m_frozen++;
    end else if (m_in_access) begin
      if (!mem_ready) m_timeout = 1'b1;
      m_in_access = 1'b0;
      m_frozen    = 0;
    end
  endfunction

  task automatic settle();
    @(negedge clk);
    model_eval();
  endtask

  task automatic advance();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_src1 = 4'd0; id_src2 = 4'd0; id_use_src2 = 1'b0;
    exe_dest = 4'd0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
    mem_dest = 4'd0; mem_wb_en = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0;
  endtask

  task automatic random_inputs();
    id_src1      = 4'($urandom_range(0, 3));
    id_src2      = 4'($urandom_range(0, 3));
    id_use_src2  = 1'($urandom_range(0, 1));
    exe_dest     = 4'($urandom_range(0, 3));
    exe_wb_en    = 1'($urandom_range(0, 1));
    exe_mem_r_en = 1'($urandom_range(0, 1));
    mem_dest     = 4'($urandom_range(0, 3));
    mem_wb_en    = 1'($urandom_range(0, 1));
    mem_req      = ($urandom_range(0, 3) == 0);
    mem_ready    = 1'($urandom_range(0, 1));
    branch_taken = ($urandom_range(0, 7) == 0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    settle();
    advance();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      random_inputs();
      settle();
      checks++;
      if ({hazard_stall, id_bubble, flush, mem_freeze, fwd_en, mem_timeout} !== exp_vec) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d got %b want %b", i,
                 {hazard_stall, id_bubble, flush, mem_freeze, fwd_en, mem_timeout}, exp_vec);
      end
      checks++;
      if (stall_count !== 16'd0) begin
        errors++;
        $display("FAIL reset_stall_count got %0d want 0", stall_count);
      end
      advance();
    end
    rst = 1'b0;
    idle_inputs();
    settle();
    checks++;
    if (stall_count !== 16'd0 || mem_timeout !== 1'b0 || mem_freeze !== 1'b0) begin
      errors++;
      $display("FAIL post_reset got cnt %0d to %b fr %b want 0 0 0", stall_count, mem_timeout, mem_freeze);
    end
    advance();
  endtask

  task automatic test_load_use();
    pulse_reset();
    idle_inputs();
    exe_mem_r_en = 1'b1; exe_wb_en = 1'b1; exe_dest = 4'd4;
    id_src1 = 4'd4; id_src2 = 4'd9;
    settle();
    checks++;
    if ({hazard_stall, id_bubble, flush, mem_freeze, fwd_en, mem_timeout} !== exp_vec) begin
      errors++;
      $display("FAIL load_use_model got %b want %b",
               {hazard_stall, id_bubble, flush, mem_freeze, fwd_en, mem_timeout}, exp_vec);
    end
    checks++;
    if (hazard_stall !== 1'b1 || id_bubble !== 1'b1) begin
      errors++;
      $display("FAIL load_use_stall got %b%b want 11", hazard_stall, id_bubble);
    end
    advance();
    // The load has moved on to MEM.
    exe_mem_r_en = 1'b0; exe_wb_en = 1'b0; exe_dest = 4'd0;
    mem_dest = 4'd4; mem_wb_en = 1'b1;
    settle();
    checks++;
    if ({hazard_stall, id_bubble, flush, mem_freeze, fwd_en, mem_timeout} !== exp_vec) begin
      errors++;
      $display("FAIL load_use_after got %b want %b",
               {hazard_stall, id_bubble, flush, mem_freeze, fwd_en, mem_timeout}, exp_vec);
    end
    checks++;
    if (stall_count !== 16'd1) begin
      errors++;
      $display("FAIL load_use_count got %0d want 1", stall_count);
    end
    advance();
    idle_inputs();
  endtask

  task automatic test_alu_dep();
    // {exe_wb_en, exe_dest, mem_wb_en, mem_dest, id_use_src2, stall_without_forwarding}
    logic [11:0] cases [3];
    cases[0] = {1'b1, 4'd3, 1'b0, 4'd8, 1'b1, 1'b1};
    cases[1] = {1'b0, 4'd8, 1'b1, 4'd3, 1'b1, 1'b1};
    cases[2] = {1'b1, 4'd3, 1'b1, 4'd3, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      idle_inputs();
      {exe_wb_en, exe_dest, mem_wb_en, mem_dest, id_use_src2} = cases[i][11:1];
      id_src1 = 4'd7; id_src2 = 4'd3;
      settle();
      checks++;
      if ({hazard_stall, id_bubble, flush, mem_freeze, fwd_en, mem_timeout} !== exp_vec) begin
        errors++;
        $display("FAIL alu_dep_model case %0d got %b want %b", i,
                 {hazard_stall, id_bubble, flush, mem_freeze, fwd_en, mem_timeout}, exp_vec);
      end
      checks++;
      if (hazard_stall !== (cases[i][0] & ~FWD)) begin
        errors++;
        $display("FAIL alu_dep_stall case %0d got %b want %b", i, hazard_stall, cases[i][0] & ~FWD);
      end
      advance();
    end
    idle_inputs();
  endtask

  task automatic test_mem_wait();
    int n = 0;
    pulse_reset();
    idle_inputs();
    mem_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mem_ready = (i >= 3);
      if (i == 4) mem_req = 1'b0;
      settle();
      checks++;
      if ({hazard_stall, id_bubble, flush, mem_freeze, fwd_en, mem_timeout} !== exp_vec ||
          stall_count !== exp_cnt) begin
        errors++;
        $display("FAIL mem_wait_model cycle %0d got %b/%0d want %b/%0d", i,
                 {hazard_stall, id_bubble, flush, mem_freeze, fwd_en, mem_timeout}, stall_count,
                 exp_vec, exp_cnt);
      end
      if (mem_freeze === 1'b1) n++;
      if (i == 3) begin
        checks++;
        if (stall_count !== 16'd3) begin
          errors++;
          $display("FAIL mem_wait_count got %0d want 3", stall_count);
        end
      end
      advance();
    end
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL mem_wait_freeze_len got %0d want 3", n);
    end
    idle_inputs();
  endtask

  task automatic test_timeout();
    int n = 0;
    bit done = 1'b0;
    pulse_reset();
    idle_inputs();
    mem_req = 1'b1;
    for (int i = 0; i < 12 && !done; i++) begin
      settle();
      checks++;
      if ({hazard_stall, id_bubble, flush, mem_freeze, fwd_en, mem_timeout} !== exp_vec) begin
        errors++;
        $display("FAIL timeout_model cycle %0d got %b want %b", i,
                 {hazard_stall, id_bubble, flush, mem_freeze, fwd_en, mem_timeout}, exp_vec);
      end
      if (mem_freeze === 1'b1) n++;
      else done = 1'b1;
      if (!done) advance();
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL timeout_bound freeze never dropped got %0d cycles want %0d", n, WAIT_MAX);
    end
    checks++;
    if (n != WAIT_MAX || mem_timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_len got %0d/%b want %0d/0", n, mem_timeout, WAIT_MAX);
    end
    advance();
    mem_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      settle();
      checks++;
      if (mem_timeout !== 1'b1 || mem_timeout !== exp_vec[0]) begin
        errors++;
        $display("FAIL timeout_sticky cycle %0d got %b want 1", i, mem_timeout);
      end
      advance();
      random_inputs();
      mem_req = 1'b0;
    end
    idle_inputs();
    pulse_reset();
    settle();
    checks++;
    if (mem_timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear got %b want 0", mem_timeout);
    end
    advance();
  endtask

  task automatic test_simultaneous();
    idle_inputs();
    branch_taken = 1'b1;
    exe_mem_r_en = 1'b1; exe_wb_en = 1'b1; exe_dest = 4'd5; id_src1 = 4'd5;
    settle();
    checks++;
    if ({hazard_stall, id_bubble, flush} !== 3'b011 || exp_vec[5:3] !== 3'b011) begin
      errors++;
      $display("FAIL branch_over_hazard got %b want 011", {hazard_stall, id_bubble, flush});
    end
    advance();
    idle_inputs();
    branch_taken = 1'b1;
    mem_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_ready = (i == 2);
      settle();
      checks++;
      if ({hazard_stall, id_bubble, flush, mem_freeze, fwd_en, mem_timeout} !== exp_vec) begin
        errors++;
        $display("FAIL branch_in_freeze_model cycle %0d got %b want %b", i,
                 {hazard_stall, id_bubble, flush, mem_freeze, fwd_en, mem_timeout}, exp_vec);
      end
      checks++;
      if (flush !== (i == 2)) begin
        errors++;
        $display("FAIL branch_in_freeze_flush cycle %0d got %b want %b", i, flush, (i == 2));
      end
      advance();
    end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      random_inputs();
      rst = ($urandom_range(0, 63) == 0);
      settle();
      checks++;
      if ({hazard_stall, id_bubble, flush, mem_freeze, fwd_en, mem_timeout} !== exp_vec) begin
        errors++;
        $display("FAIL random_outputs cycle %0d got %b want %b", i,
                 {hazard_stall, id_bubble, flush, mem_freeze, fwd_en, mem_timeout}, exp_vec);
      end
      checks++;
      if (stall_count !== exp_cnt) begin
        errors++;
        $display("FAIL random_count cycle %0d got %0d want %0d", i, stall_count, exp_cnt);
      end
      advance();
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  task automatic test_saturation_and_reset();
    pulse_reset();
    idle_inputs();
    exe_mem_r_en = 1'b1; exe_wb_en = 1'b1; exe_dest = 4'd2; id_src1 = 4'd2;
    for (int i = 0; i < 65540; i++) begin
      settle();
      advance();
    end
    settle();
    checks++;
    if (stall_count !== 16'hFFFF || exp_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL saturation got %h want ffff", stall_count);
    end
    advance();
    idle_inputs();
    mem_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      settle();
      checks++;
      if (mem_freeze !== 1'b1) begin
        errors++;
        $display("FAIL midwait_freeze cycle %0d got %b want 1", i, mem_freeze);
      end
      advance();
    end
    rst = 1'b1;
    settle();
    checks++;
    if ({hazard_stall, id_bubble, flush, mem_freeze, fwd_en, mem_timeout} !== exp_vec ||
        stall_count !== 16'd0) begin
      errors++;
      $display("FAIL midwait_rst_cycle got %b/%0d want %b/0",
               {hazard_stall, id_bubble, flush, mem_freeze, fwd_en, mem_timeout}, stall_count, exp_vec);
    end
    advance();
    rst = 1'b0;
    mem_req = 1'b0;
    settle();
    checks++;
    if (mem_freeze !== 1'b0 || stall_count !== 16'd0) begin
      errors++;
      $display("FAIL midwait_after_rst got fr %b cnt %0d want 0 0", mem_freeze, stall_count);
    end
    advance();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    m_in_access = 1'b0; m_frozen = 0; m_timeout = 1'b0; m_count = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_alu_dep();
    test_mem_wait();
    test_timeout();
    test_simultaneous();
    test_random();
    test_saturation_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
